// File: rtl/project1.sv
// -----------------------------------------------------------------------------
// project1 -- four-entry 4-bit sorter with serial output
//
// This block holds four 4-bit unsigned entries. While idle it accepts one-hot
// or multi-hot writes. On a start request it sorts the entries in place with a
// fixed six-step compare-swap network. It then streams the sorted values out
// on partE, smallest first, one value per clock.
//
// Ports
//   clk    in   1  rising-edge clock for all state
//   rst    in   1  synchronous active-high reset
//   partA  in   4  write select, bit i selects entry i (multi-hot allowed)
//   partB  in   4  write data
//   partC  in   1  load enable (level, honoured only while idle)
//   partD  in   1  sort start (level, honoured only while idle, partC wins)
//   partE  out  4  registered sorted-data output
// -----------------------------------------------------------------------------
module project1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] partA,
  input  logic [3:0] partB,
  input  logic       partC,
  input  logic       partD,
  output logic [3:0] partE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [2:0] step_q, step_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] part_e_q, part_e_d;
  logic [1:0] pair_lo;
  logic [1:0] pair_hi;

  // The compare-swap network visits the pairs (0,1) (1,2) (2,3) (0,1) (1,2)
  // (0,1). This is a bubble sort unrolled over six steps. After six steps, any
  // input order of four values ends up ascending.
  always_comb begin
    pair_lo = 2'd0;
    case (step_q)
      3'd0, 3'd3, 3'd5: pair_lo = 2'd0;
      3'd1, 3'd4:       pair_lo = 2'd1;
      3'd2:             pair_lo = 2'd2;
      default:          pair_lo = 2'd0;
    endcase
    pair_hi = pair_lo + 2'd1;
  end

  // Next-state logic. Every register holds its value by default.
  // IDLE: a write takes priority over a start request.
  // SORT: one compare-swap per clock. Equal values stay in place.
  // OUT:  one entry is registered onto partE per clock.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    step_d   = step_q;
    idx_d    = idx_q;
    part_e_d = part_e_q;

    case (state_q)
      IDLE: begin
        if (partC) begin
          for (int i = 0; i < 4; i++) begin
            if (partA[i]) begin
              mem_d[i] = partB;
            end
          end
        end else if (partD) begin
          state_d = SORT;
          step_d  = 3'd0;
        end
      end

      SORT: begin
        if (mem_q[pair_lo] > mem_q[pair_hi]) begin
          mem_d[pair_lo] = mem_q[pair_hi];
          mem_d[pair_hi] = mem_q[pair_lo];
        end
        if (step_q == 3'd5) begin
          state_d = OUT;
          step_d  = 3'd0;
          idx_d   = 2'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      OUT: begin
        part_e_d = mem_q[idx_q];
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset clears everything, including a sort or output
  // phase already in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      idx_q    <= 2'd0;
      part_e_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 4'd0;
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      part_e_q <= part_e_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign partE = part_e_q;

endmodule

// File: tb/tb_project1.sv
// -----------------------------------------------------------------------------
// tb_project1 -- self-checking bench for project1
//
// A behavioural model runs alongside the DUT. It tracks the four stored
// values. When a start request is accepted, it sorts a copy of those values
// with a queue sort. It then predicts what partE shows on each later clock:
// the sorted value i appears 7+i clocks after the start request is sampled.
// Directed scenarios come first, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_project1;

  logic       clk;
  logic       rst;
  logic [3:0] partA;
  logic [3:0] partB;
  logic       partC;
  logic       partD;
  logic [3:0] partE;

  int checks = 0;
  int errors = 0;

  // Model of the block as seen from the outside.
  logic [3:0] model_mem [4];
  logic [3:0] model_sorted [4];
  logic [3:0] model_e;
  bit         model_active;
  int         model_cnt;

  project1 dut (
    .clk   (clk),
    .rst   (rst),
    .partA (partA),
    .partB (partB),
    .partC (partC),
    .partD (partD),
    .partE (partE)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares the observed value against an expected value and records any
  // failure.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sorts the current model contents in ascending order. The sorted values
  // become both the predicted output sequence and the stored contents.
  task automatic modelSort();
    int q[$];
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(int'(model_mem[i]));
    q.sort();
    for (int i = 0; i < 4; i++) begin
      model_sorted[i] = 4'(q[i]);
      model_mem[i]    = 4'(q[i]);
    end
  endtask

  // Drives one clock's worth of inputs and advances the model by one edge.
  // After the edge it checks partE against the model.
  task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [3:0] b,
                               input logic c, input logic d, input string tag);
    rst   = r;
    partA = a;
    partB = b;
    partC = c;
    partD = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) model_mem[i] = 4'd0;
      model_active = 1'b0;
      model_cnt    = 0;
      model_e      = 4'd0;
    end else if (!model_active) begin
      if (c) begin
        for (int i = 0; i < 4; i++) if (a[i]) model_mem[i] = b;
      end else if (d) begin
        modelSort();
        model_active = 1'b1;
        model_cnt    = 0;
      end
    end else begin
      model_cnt++;
      if (model_cnt >= 7) model_e = model_sorted[model_cnt - 7];
      if (model_cnt == 10) model_active = 1'b0;
    end
    checkOutput(tag, partE, model_e);
  endtask

  // Holds partC high for several cycles to write one or more entries
  task automatic loadEntry(input logic [3:0] a, input logic [3:0] b, input int cycles);
    for (int n = 0; n < cycles; n++) applyStimulus(1'b0, a, b, 1'b1, 1'b0, "load");
  endtask

  // Starts a sort with partD held for dCycles clocks. It then checks partE
  // against the four expected constants on clocks k+7..k+10, and checks that
  // partE holds the largest value afterwards. With poke set, a write of 0 to
  // every entry is attempted during SORT; the block must ignore it.
  task automatic sortAndExpect(input int dCycles, input bit poke,
                               input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3,
                               input string tag);
    logic [3:0] expSeq [4];
    expSeq[0] = e0; expSeq[1] = e1; expSeq[2] = e2; expSeq[3] = e3;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, {tag, "_start"});
    for (int n = 1; n <= 12; n++) begin
      if (poke && n == 2)
        applyStimulus(1'b0, 4'hf, 4'h0, 1'b1, 1'b0, {tag, "_poke"});
      else
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, n < dCycles, {tag, "_run"});
      if (n >= 7 && n <= 10)
        checkOutput($sformatf("%s_out%0d", tag, n - 7), partE, expSeq[n - 7]);
      else if (n > 10)
        checkOutput({tag, "_hold"}, partE, e3);
    end
  endtask

  // Top-level sequence: reset, the directed scenarios, then random traffic
  initial begin
    rst = 1'b1; partA = 4'h0; partB = 4'h0; partC = 1'b0; partD = 1'b0;
    model_active = 1'b0; model_cnt = 0; model_e = 4'd0;
    for (int i = 0; i < 4; i++) begin
      model_mem[i] = 4'd0;
      model_sorted[i] = 4'd0;
    end

    $display("[TB] reset");
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "reset");
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "reset");
    checkOutput("reset_value", partE, 4'd0);

    $display("[TB] basic load and sort");
    loadEntry(4'b0001, 4'b1010, 5);
    loadEntry(4'b0010, 4'b0101, 5);
    loadEntry(4'b0100, 4'b1110, 5);
    loadEntry(4'b1000, 4'b0110, 5);
    sortAndExpect(5, 1'b0, 4'd5, 4'd6, 4'd10, 4'd14, "basic");

    $display("[TB] duplicates");
    loadEntry(4'b0001, 4'd3, 1);
    loadEntry(4'b0010, 4'd3, 1);
    loadEntry(4'b0100, 4'd1, 1);
    loadEntry(4'b1000, 4'd3, 1);
    sortAndExpect(1, 1'b0, 4'd1, 4'd3, 4'd3, 4'd3, "dups");

    $display("[TB] already sorted and reversed");
    loadEntry(4'b0001, 4'd0, 1);
    loadEntry(4'b0010, 4'd1, 1);
    loadEntry(4'b0100, 4'd2, 1);
    loadEntry(4'b1000, 4'd15, 1);
    sortAndExpect(1, 1'b0, 4'd0, 4'd1, 4'd2, 4'd15, "sorted");
    loadEntry(4'b0001, 4'd15, 1);
    loadEntry(4'b0010, 4'd9, 1);
    loadEntry(4'b0100, 4'd4, 1);
    loadEntry(4'b1000, 4'd0, 1);
    sortAndExpect(1, 1'b0, 4'd0, 4'd4, 4'd9, 4'd15, "reverse");

    $display("[TB] write priority and ignore during sort");
    // Stored contents are now 0,4,9,15. A write with start also high must
    // replace entry 0, and no sort may start.
    applyStimulus(1'b0, 4'b0001, 4'd12, 1'b1, 1'b1, "prio");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "prio_idle");
      checkOutput("prio_nostart", partE, 4'd15);
    end
    sortAndExpect(1, 1'b1, 4'd4, 4'd9, 4'd12, 4'd15, "ignore");

    $display("[TB] multi-hot write");
    loadEntry(4'b1111, 4'b0111, 1);
    sortAndExpect(1, 1'b0, 4'd7, 4'd7, 4'd7, 4'd7, "multihot");

    $display("[TB] reset during sort");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, "rstmid_start");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "rstmid_run");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "rstmid_run");
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "rstmid_rst");
    checkOutput("rstmid_cleared", partE, 4'd0);
    sortAndExpect(1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, "rstmid_zero");

    $display("[TB] random traffic");
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom % 97) == 0, 4'($urandom), 4'($urandom),
                    ($urandom % 4) == 0, ($urandom % 6) == 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
